// File: rtl/cosmem_hardware.sv
// cosmem_hardware: clock source, reset generator and one 256-byte RAM page
// for a COSMAC-style CPU on a multiplexed 8-bit address bus.
//
// Ports
//   clk_16mhz         system clock
//   reset             synchronous active-high reset
//   pin_1             XCLK to the CPU
//   pin_2             nWAIT (constant 1)
//   pin_3             nCLEAR, low after reset until CLR_CYCLES XCLK rises
//   pin_4 / pin_5     nMWR / nMRD strobes (active low)
//   pin_6 / pin_7     TPA / TPB timing pulses
//   pin_15..pin_8     MA0..MA7
//   pin_16..pin_23    DB0..DB7 (bidirectional, hi-Z unless reading our page)
//   leds              mirror of writes to LED_OFFSET in the page
//
// Handshake: the CPU bus has no valid/ready. A write is the low period of
// nMWR; it commits once the synchronized nMWR is seen rising. A read drives
// DB while synchronized nMRD is low, nMWR is high and the page matches.

module cosmem_ram (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata
);
  // No reset: contents survive a CPU reset.
  logic [7:0] mem [0:255];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end
endmodule

module cosmem_hardware #(
  parameter logic [7:0] PAGE       = 8'hF0,
  parameter logic [7:0] LED_OFFSET = 8'h0F,
  parameter int         XCLK_HALF  = 4,
  parameter int         CLR_CYCLES = 64
) (
  input  logic       clk_16mhz,
  input  logic       reset,
  output logic       pin_1,
  output logic       pin_2,
  output logic       pin_3,
  input  logic       pin_4,
  input  logic       pin_5,
  input  logic       pin_6,
  input  logic       pin_7,
  input  logic       pin_8,
  input  logic       pin_9,
  input  logic       pin_10,
  input  logic       pin_11,
  input  logic       pin_12,
  input  logic       pin_13,
  input  logic       pin_14,
  input  logic       pin_15,
  inout  wire        pin_16,
  inout  wire        pin_17,
  inout  wire        pin_18,
  inout  wire        pin_19,
  inout  wire        pin_20,
  inout  wire        pin_21,
  inout  wire        pin_22,
  inout  wire        pin_23,
  output logic [7:0] leds
);
  localparam int DIV_W = $clog2(XCLK_HALF);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  // Clock divider and CLEAR generator
  logic [DIV_W-1:0] r_div;
  logic             r_xclk;
  logic [CLR_W-1:0] r_clr_cnt;
  logic             r_nclear;

  // Synchronizers; the *_s3 stage holds the previous synchronized value
  // for edge detection.
  logic r_mwr_s1, r_mwr_s2, r_mwr_s3;
  logic r_mrd_s1, r_mrd_s2;
  logic r_tpa_s1, r_tpa_s2, r_tpa_s3;
  logic r_tpb_s1, r_tpb_s2;
  logic [7:0] r_ma_s1, r_ma_s2;
  logic [7:0] r_db_s1, r_db_s2;

  logic [7:0] r_hi_addr;
  logic [7:0] r_cap_ma;
  logic [7:0] r_cap_db;
  logic [7:0] r_leds;

  logic [7:0] w_ma;
  logic [7:0] w_db_in;
  logic [7:0] w_rd_data;
  logic       w_xrise;
  logic       w_div_end;
  logic       w_page_hit;
  logic       w_mwr_rise;
  logic       w_tpa_fall;
  logic       w_we;
  logic       w_db_oe;
  logic       w_unused_tpb;

  assign w_ma    = {pin_8, pin_9, pin_10, pin_11, pin_12, pin_13, pin_14, pin_15};
  assign w_db_in = {pin_23, pin_22, pin_21, pin_20, pin_19, pin_18, pin_17, pin_16};

  assign w_div_end  = (r_div == DIV_W'(XCLK_HALF - 1));
  assign w_xrise    = w_div_end & ~r_xclk;
  assign w_page_hit = (r_hi_addr == PAGE);
  assign w_mwr_rise = r_mwr_s2 & ~r_mwr_s3;
  assign w_tpa_fall = ~r_tpa_s2 & r_tpa_s3;
  // Reset is gated in so a write pending at reset can never land.
  assign w_we       = w_mwr_rise & w_page_hit & ~reset;
  // Write wins over read when both strobes are low.
  assign w_db_oe    = ~r_mrd_s2 & r_mwr_s2 & w_page_hit;
  assign w_unused_tpb = r_tpb_s2;

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      r_div     <= '0;
      r_xclk    <= 1'b0;
      r_clr_cnt <= '0;
      r_nclear  <= 1'b0;
      r_mwr_s1  <= 1'b1;
      r_mwr_s2  <= 1'b1;
      r_mwr_s3  <= 1'b1;
      r_mrd_s1  <= 1'b1;
      r_mrd_s2  <= 1'b1;
      r_tpa_s1  <= 1'b0;
      r_tpa_s2  <= 1'b0;
      r_tpa_s3  <= 1'b0;
      r_tpb_s1  <= 1'b0;
      r_tpb_s2  <= 1'b0;
      r_ma_s1   <= '0;
      r_ma_s2   <= '0;
      r_db_s1   <= '0;
      r_db_s2   <= '0;
      r_hi_addr <= '0;
      r_cap_ma  <= '0;
      r_cap_db  <= '0;
      r_leds    <= '0;
    end else begin
      if (w_div_end) begin
        r_div  <= '0;
        r_xclk <= ~r_xclk;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_xrise && !r_nclear) begin
        if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) r_nclear <= 1'b1;
        else r_clr_cnt <= r_clr_cnt + 1'b1;
      end

      r_mwr_s1 <= pin_4;
      r_mwr_s2 <= r_mwr_s1;
      r_mwr_s3 <= r_mwr_s2;
      r_mrd_s1 <= pin_5;
      r_mrd_s2 <= r_mrd_s1;
      r_tpa_s1 <= pin_6;
      r_tpa_s2 <= r_tpa_s1;
      r_tpa_s3 <= r_tpa_s2;
      r_tpb_s1 <= pin_7;
      r_tpb_s2 <= r_tpb_s1;
      r_ma_s1  <= w_ma;
      r_ma_s2  <= r_ma_s1;
      r_db_s1  <= w_db_in;
      r_db_s2  <= r_db_s1;

      if (w_tpa_fall) r_hi_addr <= r_ma_s2;

      // The last sample taken with nMWR low is what commits, so bus
      // changes at or after the rising edge do not disturb the write.
      if (!r_mwr_s2) begin
        r_cap_ma <= r_ma_s2;
        r_cap_db <= r_db_s2;
      end

      if (w_we && r_cap_ma == LED_OFFSET) r_leds <= r_cap_db;
    end
  end

  cosmem_ram memory (
    .i_clk   (clk_16mhz),
    .i_we    (w_we),
    .i_waddr (r_cap_ma),
    .i_wdata (r_cap_db),
    .i_raddr (r_ma_s2),
    .o_rdata (w_rd_data)
  );

  assign pin_1 = r_xclk;
  assign pin_2 = 1'b1;
  assign pin_3 = r_nclear;
  assign leds  = r_leds;

  assign pin_16 = w_db_oe ? w_rd_data[0] : 1'bz;
  assign pin_17 = w_db_oe ? w_rd_data[1] : 1'bz;
  assign pin_18 = w_db_oe ? w_rd_data[2] : 1'bz;
  assign pin_19 = w_db_oe ? w_rd_data[3] : 1'bz;
  assign pin_20 = w_db_oe ? w_rd_data[4] : 1'bz;
  assign pin_21 = w_db_oe ? w_rd_data[5] : 1'bz;
  assign pin_22 = w_db_oe ? w_rd_data[6] : 1'bz;
  assign pin_23 = w_db_oe ? w_rd_data[7] : 1'bz;
endmodule

// File: tb/tb_cosmem_hardware.sv
// Bench for cosmem_hardware. The data bus has pull-ups, so a released bus
// reads 8'hFF; written data therefore never uses 8'hFF.
module tb_cosmem_hardware;
  localparam logic [7:0] PAGE = 8'hF0;
  localparam logic [7:0] LED_OFF = 8'h0F;
  localparam logic [7:0] HIZ = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       n_mwr = 1'b1, n_mrd = 1'b1, tpa = 1'b0, tpb = 1'b0;
  logic [7:0] ma = '0;
  logic [7:0] db_drv = '0;
  logic       db_oe = 1'b0;
  logic       xclk, nwait, nclear;
  logic [7:0] leds;
  wire  [7:0] db;

  assign db = db_oe ? db_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (db[g]);
  end

  // Reference model state
  logic [7:0] mem_m [0:255];
  bit         valid_m [0:255];
  logic [7:0] hi_m = '0;
  logic [7:0] leds_m = '0;

  int n_checks = 0;
  int n_fail   = 0;

  cosmem_hardware dut (
    .clk_16mhz(clk), .reset(reset),
    .pin_1(xclk), .pin_2(nwait), .pin_3(nclear),
    .pin_4(n_mwr), .pin_5(n_mrd), .pin_6(tpa), .pin_7(tpb),
    .pin_8(ma[7]), .pin_9(ma[6]), .pin_10(ma[5]), .pin_11(ma[4]),
    .pin_12(ma[3]), .pin_13(ma[2]), .pin_14(ma[1]), .pin_15(ma[0]),
    .pin_16(db[0]), .pin_17(db[1]), .pin_18(db[2]), .pin_19(db[3]),
    .pin_20(db[4]), .pin_21(db[5]), .pin_22(db[6]), .pin_23(db[7]),
    .leds(leds)
  );

  // Clock / reset block
  always #31 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic do_tpa(input logic [7:0] hi);
    ma = hi; tpa = 1'b1;
    tick(4);
    tpa = 1'b0;
    tick(4);
    hi_m = hi;
  endtask

  task automatic do_write(input logic [7:0] off, input logic [7:0] data);
    ma = off; db_drv = data; db_oe = 1'b1; n_mwr = 1'b0;
    tick(4);
    // Bus changes together with the strobe release; the write must not care.
    n_mwr = 1'b1; db_oe = 1'b0; ma = 8'($urandom_range(0, 255));
    tick(6);
    if (hi_m == PAGE) begin
      mem_m[off] = data;
      valid_m[off] = 1'b1;
      if (off == LED_OFF) leds_m = data;
    end
    check("leds", leds, leds_m);
  endtask

  task automatic do_read(input logic [7:0] off);
    ma = off; n_mrd = 1'b0;
    tick(4);
    if (hi_m != PAGE) check("rd_hiz", db, HIZ);
    else if (valid_m[off]) check("rd_data", db, mem_m[off]);
    n_mrd = 1'b1;
    tick(3);
    check("rd_release", db, HIZ);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) valid_m[i] = 1'b0;

    // Reset state
    tick(4);
    check("rst_xclk", xclk, 1'b0);
    check("rst_nwait", nwait, 1'b1);
    check("rst_nclear", nclear, 1'b0);
    check("rst_leds", leds, 8'h00);
    check("rst_db", db, HIZ);
    reset = 1'b0;

    // XCLK toggles every 4 clocks; nCLEAR releases at the 64th XCLK rise.
    for (int n = 1; n <= 540; n++) begin
      int rises;
      tick(1);
      rises = ((n / 4) + 1) / 2;
      check("xclk", xclk, (n / 4) % 2);
      check("nwait", nwait, 1'b1);
      check("nclear", nclear, (rises >= 64) ? 1'b1 : 1'b0);
    end

    // Fill offsets 0..15 of the page
    do_tpa(PAGE);
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'(8'hC5 + (i & 7)));
    check("leds_cc", leds, 8'hCC);
    do_write(8'h0E, 8'h3A);
    check("leds_keep", leds, 8'hCC);
    do_write(8'h0E, 8'hC5 + 8'd6);
    for (int i = 0; i < 16; i++) do_read(8'(i));
    do_read(8'h03);

    // Off-page write ignored, off-page read leaves bus released
    do_tpa(8'h00);
    do_write(8'h02, 8'h55);
    do_read(8'h02);
    do_tpa(PAGE);
    do_read(8'h02);
    check("mem2_kept", mem_m[2], 8'hC7);

    // Reset during an active write
    ma = 8'h05; db_drv = 8'h11; db_oe = 1'b1; n_mwr = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    n_mwr = 1'b1; db_oe = 1'b0;
    tick(3);
    check("rstw_nclear", nclear, 1'b0);
    check("rstw_xclk", xclk, 1'b0);
    check("rstw_leds", leds, 8'h00);
    reset = 1'b0;
    hi_m = '0; leds_m = '0;
    tick(2);
    do_read(8'h05);
    do_tpa(PAGE);
    do_read(8'h05);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: do_tpa(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : PAGE);
        1, 2: do_write(($urandom_range(0, 3) == 0) ? LED_OFF : 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 254)));
        default: do_read(8'($urandom_range(0, 255)));
      endcase
    end
    do_tpa(PAGE);
    for (int i = 0; i < 16; i++) do_read(8'(i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
